// File: rtl/onehot_mon_pkg.sv
// Shared types and helpers for the decoder one-hot health monitor.
package onehot_mon_pkg;

  localparam int NUM_LINES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_t;

  // Returns {valid, idx}; valid is 0 for zero or multiple bits set.
  function automatic logic [2:0] onehot_idx(input logic [NUM_LINES-1:0] v);
    logic [2:0] r;
    r = 3'b000;
    case (v)
      4'b0001: r = 3'b100;
      4'b0010: r = 3'b101;
      4'b0100: r = 3'b110;
      4'b1000: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/onehot_monitor.sv
// Samples decoder outputs, counts per-line hits and non-one-hot cycles,
// and hands a frozen snapshot of the counters to a reader.
module onehot_monitor
  import onehot_mon_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d0,
  input  logic             d1,
  input  logic             d2,
  input  logic             d3,
  input  logic             clr,
  input  logic             snap_req,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  output logic [CNT_W-1:0] err_cnt,
  output logic             onehot_err,
  output logic [1:0]       last_idx,
  output snap_state_t      dbg_state
);

  logic [NUM_LINES-1:0] r_smp;
  logic                 r_smp_v;
  logic                 r_onehot_err;
  logic [1:0]           r_last_idx;
  snap_state_t          r_state;
  logic                 r_snap_valid;
  logic [CNT_W-1:0]     r_snap_hit [NUM_LINES];
  logic [CNT_W-1:0]     r_snap_err;

  logic [2:0]           w_class;
  logic                 w_valid;
  logic [1:0]           w_idx;
  logic [NUM_LINES-1:0] w_hit_inc;
  logic                 w_err_inc;
  logic [CNT_W-1:0]     w_hit_q [NUM_LINES];
  logic [CNT_W-1:0]     w_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp   <= '0;
      r_smp_v <= 1'b0;
    end else begin
      r_smp_v <= en;
      if (en) begin
        r_smp <= {d3, d2, d1, d0};
      end
    end
  end

  assign w_class   = onehot_idx(r_smp);
  assign w_valid   = w_class[2];
  assign w_idx     = w_class[1:0];
  assign w_err_inc = r_smp_v & ~w_valid;

  genvar g;
  for (g = 0; g < NUM_LINES; g++) begin : g_line
    assign w_hit_inc[g] = r_smp_v & w_valid & (w_idx == 2'(g));
    sat_counter #(.W(CNT_W)) u_hit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (w_hit_inc[g]),
      .q     (w_hit_q[g])
    );
  end

  sat_counter #(.W(CNT_W)) u_err (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (w_err_inc),
    .q     (w_err_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_onehot_err <= 1'b0;
      r_last_idx   <= 2'd0;
    end else begin
      r_onehot_err <= w_err_inc;
      if (r_smp_v && w_valid) begin
        r_last_idx <= w_idx;
      end
    end
  end

  // Handshake: snap_valid stays high with outputs frozen until a cycle in
  // which snap_ready is also high; the transfer completes on that edge.
  // The capture reads the counters' current values, so a same-edge
  // increment or clr only affects the live counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_snap_valid <= 1'b0;
      r_snap_hit   <= '{default: '0};
      r_snap_err   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (snap_req) begin
            r_snap_hit   <= w_hit_q;
            r_snap_err   <= w_err_q;
            r_state      <= HOLD;
            r_snap_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (snap_ready) begin
            r_state      <= IDLE;
            r_snap_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_snap_valid <= 1'b0;
        end
      endcase
    end
  end

  assign snap_valid = r_snap_valid;
  assign cnt0       = r_snap_hit[0];
  assign cnt1       = r_snap_hit[1];
  assign cnt2       = r_snap_hit[2];
  assign cnt3       = r_snap_hit[3];
  assign err_cnt    = r_snap_err;
  assign onehot_err = r_onehot_err;
  assign last_idx   = r_last_idx;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_onehot_monitor.sv
// Directed bench for onehot_monitor built with 4-bit counters so saturation is reachable.
module tb_onehot_monitor;
  import onehot_mon_pkg::*;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             d0, d1, d2, d3;
  logic             clr;
  logic             snap_req;
  logic             snap_valid;
  logic             snap_ready;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3, err_cnt;
  logic             onehot_err;
  logic [1:0]       last_idx;
  snap_state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  onehot_monitor #(.CNT_W(CNT_W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .clr        (clr),
    .snap_req   (snap_req),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .cnt2       (cnt2),
    .cnt3       (cnt3),
    .err_cnt    (err_cnt),
    .onehot_err (onehot_err),
    .last_idx   (last_idx),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are read on the falling edge.
  function automatic logic [3:0] dec2to4(input logic [1:0] ab);
    logic [3:0] one;
    one = 4'b0001;
    return one << ab;
  endfunction

  task automatic set_d(input logic [3:0] v);
    {d3, d2, d1, d0} = v;
  endtask

  task automatic clr_live();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic snap_capture();
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
  endtask

  task automatic snap_release();
    snap_ready = 1'b1;
    @(negedge clk);
    snap_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; set_d(4'b0001); clr = 1'b0;
    snap_req = 1'b1; snap_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({snap_valid, cnt0, cnt1, cnt2, cnt3, err_cnt, onehot_err, last_idx} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got valid=%b c=%0d,%0d,%0d,%0d err=%0d oe=%b li=%0d want all 0",
               snap_valid, cnt0, cnt1, cnt2, cnt3, err_cnt, onehot_err, last_idx);
    end
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_errors++; $display("FAIL reset_state got %0d want IDLE", dbg_state);
    end
    en = 1'b0; set_d(4'b0000); snap_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hits();
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_d(dec2to4(2'(k)));
      @(negedge clk);
    end
    en = 1'b0; set_d(4'b0000);
    @(negedge clk);
    snap_capture();
    n_checks++;
    if (snap_valid !== 1'b1) begin
      n_errors++; $display("FAIL hits_valid got %b want 1", snap_valid);
    end
    n_checks++;
    if ({cnt0, cnt1, cnt2, cnt3} !== {4'd1, 4'd1, 4'd1, 4'd1}) begin
      n_errors++; $display("FAIL hits_counts got %0d,%0d,%0d,%0d want 1,1,1,1", cnt0, cnt1, cnt2, cnt3);
    end
    n_checks++;
    if (err_cnt !== 4'd0) begin
      n_errors++; $display("FAIL hits_err got %0d want 0", err_cnt);
    end
    n_checks++;
    if (last_idx !== 2'd3) begin
      n_errors++; $display("FAIL hits_last_idx got %0d want 3", last_idx);
    end
    snap_release();
    n_checks++;
    if (snap_valid !== 1'b0) begin
      n_errors++; $display("FAIL hits_release got %b want 0", snap_valid);
    end
  endtask

  task automatic test_errors();
    logic [4:0] exp_pulse;
    exp_pulse = 5'b01110;
    clr_live();
    en = 1'b1; set_d(4'b0000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (onehot_err !== exp_pulse[k]) begin
        n_errors++; $display("FAIL err_pulse[%0d] got %b want %b", k, onehot_err, exp_pulse[k]);
      end
      if (k == 1) set_d(4'b0101);
      if (k == 2) begin en = 1'b0; set_d(4'b0000); end
    end
    n_checks++;
    if (last_idx !== 2'd3) begin
      n_errors++; $display("FAIL err_last_idx_hold got %0d want 3", last_idx);
    end
    snap_capture();
    n_checks++;
    if (err_cnt !== 4'd3) begin
      n_errors++; $display("FAIL err_count got %0d want 3", err_cnt);
    end
    n_checks++;
    if ({cnt0, cnt1, cnt2, cnt3} !== 16'h0000) begin
      n_errors++; $display("FAIL err_hits got %0d,%0d,%0d,%0d want 0,0,0,0", cnt0, cnt1, cnt2, cnt3);
    end
    snap_release();
  endtask

  task automatic test_saturation();
    clr_live();
    en = 1'b1; set_d(4'b0001);
    repeat (20) @(negedge clk);
    en = 1'b0; set_d(4'b0000);
    repeat (2) @(negedge clk);
    snap_capture();
    n_checks++;
    if (cnt0 !== 4'd15) begin
      n_errors++; $display("FAIL sat_cnt0 got %0d want 15", cnt0);
    end
    n_checks++;
    if ({cnt1, cnt2, cnt3, err_cnt} !== 16'h0000) begin
      n_errors++; $display("FAIL sat_others got %0d,%0d,%0d err=%0d want 0", cnt1, cnt2, cnt3, err_cnt);
    end
    n_checks++;
    if (last_idx !== 2'd0) begin
      n_errors++; $display("FAIL sat_last_idx got %0d want 0", last_idx);
    end
    snap_release();
  endtask

  task automatic test_hold_freeze();
    clr_live();
    en = 1'b1; set_d(4'b0010);
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1; snap_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if ({snap_valid, cnt1} !== {1'b1, 4'd3}) begin
        n_errors++; $display("FAIL hold_frozen[%0d] got valid=%b cnt1=%0d want valid=1 cnt1=3", k, snap_valid, cnt1);
      end
    end
    en = 1'b0; snap_req = 1'b0; set_d(4'b0000);
    snap_release();
    n_checks++;
    if (snap_valid !== 1'b0) begin
      n_errors++; $display("FAIL hold_release got %b want 0", snap_valid);
    end
    snap_capture();
    n_checks++;
    if ({snap_valid, cnt1} !== {1'b1, 4'd8}) begin
      n_errors++; $display("FAIL back_to_back got valid=%b cnt1=%0d want valid=1 cnt1=8", snap_valid, cnt1);
    end
    snap_release();
  endtask

  task automatic test_clr_snap();
    clr_live();
    en = 1'b1; set_d(4'b0100);
    repeat (7) @(negedge clk);
    en = 1'b0; set_d(4'b0000);
    @(negedge clk);
    clr = 1'b1; snap_req = 1'b1;
    @(negedge clk);
    clr = 1'b0; snap_req = 1'b0;
    n_checks++;
    if ({snap_valid, cnt2} !== {1'b1, 4'd7}) begin
      n_errors++; $display("FAIL clr_snap_pre got valid=%b cnt2=%0d want valid=1 cnt2=7", snap_valid, cnt2);
    end
    snap_release();
    repeat (2) @(negedge clk);
    snap_capture();
    n_checks++;
    if (cnt2 !== 4'd0) begin
      n_errors++; $display("FAIL clr_snap_post got %0d want 0", cnt2);
    end
    snap_release();
  endtask

  task automatic test_reset_mid_hold();
    clr_live();
    en = 1'b1; set_d(4'b1000);
    repeat (3) @(negedge clk);
    en = 1'b0; set_d(4'b0000);
    @(negedge clk);
    snap_capture();
    n_checks++;
    if ({snap_valid, cnt3} !== {1'b1, 4'd3}) begin
      n_errors++; $display("FAIL rst_pre got valid=%b cnt3=%0d want valid=1 cnt3=3", snap_valid, cnt3);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({snap_valid, cnt0, cnt1, cnt2, cnt3, err_cnt, last_idx} !== '0) begin
      n_errors++;
      $display("FAIL rst_async got valid=%b c=%0d,%0d,%0d,%0d err=%0d li=%0d want all 0",
               snap_valid, cnt0, cnt1, cnt2, cnt3, err_cnt, last_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1; set_d(4'b0001);
    @(negedge clk);
    en = 1'b0; set_d(4'b0000);
    @(negedge clk);
    snap_capture();
    n_checks++;
    if ({cnt0, cnt1, cnt2, cnt3, err_cnt} !== {4'd1, 4'd0, 4'd0, 4'd0, 4'd0}) begin
      n_errors++;
      $display("FAIL rst_post got %0d,%0d,%0d,%0d err=%0d want 1,0,0,0 err=0", cnt0, cnt1, cnt2, cnt3, err_cnt);
    end
    snap_release();
  endtask

  initial begin
    test_reset();
    test_hits();
    test_errors();
    test_saturation();
    test_hold_freeze();
    test_clr_snap();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
